// File: rtl/skinny_tweakey_pkg.sv
// -----------------------------------------------------------------------------
// skinny_tweakey_pkg
// Shared definitions for the SKINNY tweakey schedule:
//   - tk_state_e  : schedule FSM states (IDLE waiting for a master tweakey,
//                   RUN presenting round tweakeys)
//   - PERM        : cell permutation, out[i] = in[PERM[i]]
//   - lfsr_tk2_*  : per-cell LFSR applied to TK2 cells 8..15 (W = 8 / 4)
//   - lfsr_tk3_*  : per-cell LFSR applied to TK3 cells 8..15 (W = 8 / 4)
// No ports (package).
// -----------------------------------------------------------------------------
package skinny_tweakey_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tk_state_e;

    localparam int unsigned PERM [16] = '{8, 9, 10, 11, 12, 13, 14, 15,
                                          4, 3, 1, 5, 2, 7, 0, 6};

    // TK2: shift left, feedback x7 ^ x5 into bit 0
    function automatic logic [7:0] lfsr_tk2_w8(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5]};
    endfunction

    // TK2 (4-bit cells): shift left, feedback x3 ^ x2 into bit 0
    function automatic logic [3:0] lfsr_tk2_w4(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    // TK3: shift right, feedback x0 ^ x6 into bit 7
    function automatic logic [7:0] lfsr_tk3_w8(input logic [7:0] x);
        return {x[0] ^ x[6], x[7:1]};
    endfunction

    // TK3 (4-bit cells): shift right, feedback x0 ^ x3 into bit 3
    function automatic logic [3:0] lfsr_tk3_w4(input logic [3:0] x);
        return {x[0] ^ x[3], x[3:1]};
    endfunction

endpackage

// File: rtl/tweakey_word_update.sv
// -----------------------------------------------------------------------------
// tweakey_word_update
// One combinational round update of a single 16-cell tweakey word: cell
// permutation followed, for TK2/TK3, by the cell LFSR on cells 8..15.
// Parameters:
//   W        : cell width (4 or 8)
//   WORD_IDX : 0 = TK1 (permute only), 1 = TK2, 2 = TK3
// Ports:
//   word_in  [16*W-1:0] : current word, cell k at bits [(k+1)W-1:kW]
//   word_out [16*W-1:0] : updated word, same layout
// -----------------------------------------------------------------------------
module tweakey_word_update
    import skinny_tweakey_pkg::*;
#(
    parameter int W        = 8,
    parameter int WORD_IDX = 0
) (
    input  logic [16*W-1:0] word_in,
    output logic [16*W-1:0] word_out
);

    function automatic logic [W-1:0] lfsr_cell(input logic [W-1:0] x);
        logic [7:0] y;
        y = '0;
        if (WORD_IDX == 1) begin
            y = (W == 8) ? lfsr_tk2_w8(8'(x)) : {4'b0, lfsr_tk2_w4(x[3:0])};
        end else if (WORD_IDX == 2) begin
            y = (W == 8) ? lfsr_tk3_w8(8'(x)) : {4'b0, lfsr_tk3_w4(x[3:0])};
        end else begin
            y = 8'(x);
        end
        return y[W-1:0];
    endfunction

    logic [W-1:0] perm_cell [16];

    for (genvar i = 0; i < 16; i++) begin : g_cell
        assign perm_cell[i] = word_in[PERM[i]*W +: W];
        // Only the upper half of TK2/TK3 runs through the LFSR
        if (i < 8 || WORD_IDX == 0) begin : g_plain
            assign word_out[i*W +: W] = perm_cell[i];
        end else begin : g_lfsr
            assign word_out[i*W +: W] = lfsr_cell(perm_cell[i]);
        end
    end

endmodule

// File: rtl/skinny_tweakey_sched.sv
// -----------------------------------------------------------------------------
// skinny_tweakey_sched
// SKINNY tweakey schedule. Loads a master tweakey (TK1..TKn) and presents one
// round tweakey per handshake, advancing all words by one round each time.
// Optional feature macro: TWEAKEY_REWIND_EN -- keeps a shadow of the master
// tweakey so that 'rewind' restarts the schedule at round 0.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   tk_in             : master tweakey, NTK*16*W bits, TK1 in the LSB word
//   load_valid/ready  : master tweakey load handshake (ready only in IDLE)
//   rtk               : round tweakey, cells 8..15 of all words XORed
//   rtk_valid/ready   : round tweakey handshake (valid only in RUN)
//   round             : index of the presented round tweakey
//   last              : presented round is ROUNDS-1
//   rewind            : restart at round 0 (ignored unless TWEAKEY_REWIND_EN)
// -----------------------------------------------------------------------------
module skinny_tweakey_sched
    import skinny_tweakey_pkg::*;
#(
    parameter int W      = 8,
    parameter int NTK    = 3,
    parameter int ROUNDS = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NTK*16*W-1:0]   tk_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [8*W-1:0]        rtk,
    output logic                  rtk_valid,
    input  logic                  rtk_ready,
    output logic [5:0]            round,
    output logic                  last,
    input  logic                  rewind
);

    localparam int         WORD_BITS  = 16 * W;
    localparam int         TK_BITS    = NTK * WORD_BITS;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    tk_state_e          state_q, state_d;
    logic [5:0]         round_q, round_d;
    logic [TK_BITS-1:0] tk_q, tk_d;
    logic [TK_BITS-1:0] tk_next;

    logic load_fire;
    logic rtk_fire;
    logic rewind_fire;

    for (genvar w = 0; w < NTK; w++) begin : g_word
        tweakey_word_update #(
            .W        (W),
            .WORD_IDX (w)
        ) u_word_update (
            .word_in  (tk_q[w*WORD_BITS +: WORD_BITS]),
            .word_out (tk_next[w*WORD_BITS +: WORD_BITS])
        );
    end

    assign load_ready = (state_q == ST_IDLE);
    assign rtk_valid  = (state_q == ST_RUN);
    assign load_fire  = load_valid && load_ready;
    assign rtk_fire   = rtk_valid && rtk_ready;
    assign round      = round_q;
    assign last       = rtk_valid && (round_q == LAST_ROUND);

`ifdef TWEAKEY_REWIND_EN
    logic [TK_BITS-1:0] shadow_q, shadow_d;

    assign rewind_fire = rewind && rtk_valid;

    always_comb begin
        shadow_d = shadow_q;
        if (load_fire) begin
            shadow_d = tk_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_rewind;
    assign unused_rewind = rewind;
    assign rewind_fire   = 1'b0;
`endif

    // Rewind takes priority over a simultaneous round-tweakey handshake
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        tk_d    = tk_q;
        if (load_fire) begin
            tk_d    = tk_in;
            round_d = '0;
            state_d = ST_RUN;
        end else if (rewind_fire) begin
`ifdef TWEAKEY_REWIND_EN
            tk_d    = shadow_q;
`endif
            round_d = '0;
        end else if (rtk_fire) begin
            if (round_q == LAST_ROUND) begin
                state_d = ST_IDLE;
            end else begin
                tk_d    = tk_next;
                round_d = round_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            tk_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            tk_q    <= tk_d;
        end
    end

    // Round tweakey: XOR of the upper eight cells of every word
    always_comb begin
        rtk = '0;
        for (int w = 0; w < NTK; w++) begin
            rtk = rtk ^ tk_q[w*WORD_BITS + 8*W +: 8*W];
        end
    end

endmodule

// File: tb/tb_skinny_tweakey_sched.sv
module tb_skinny_tweakey_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: NTK=1, W=8, ROUNDS=3 (directed known-answer checks)
    logic [127:0] a_tk_in;
    logic         a_load_valid, a_load_ready;
    logic [63:0]  a_rtk;
    logic         a_rtk_valid, a_rtk_ready;
    logic [5:0]   a_round;
    logic         a_last, a_rewind;

    // Instance B: NTK=3, W=8, ROUNDS=56 (random stimulus vs reference model)
    logic [383:0] b_tk_in;
    logic         b_load_valid, b_load_ready;
    logic [63:0]  b_rtk;
    logic         b_rtk_valid, b_rtk_ready;
    logic [5:0]   b_round;
    logic         b_last, b_rewind;

    skinny_tweakey_sched #(.W(8), .NTK(1), .ROUNDS(3)) dut_a (
        .clk(clk), .rst(rst), .tk_in(a_tk_in),
        .load_valid(a_load_valid), .load_ready(a_load_ready),
        .rtk(a_rtk), .rtk_valid(a_rtk_valid), .rtk_ready(a_rtk_ready),
        .round(a_round), .last(a_last), .rewind(a_rewind)
    );

    skinny_tweakey_sched #(.W(8), .NTK(3), .ROUNDS(56)) dut_b (
        .clk(clk), .rst(rst), .tk_in(b_tk_in),
        .load_valid(b_load_valid), .load_ready(b_load_ready),
        .rtk(b_rtk), .rtk_valid(b_rtk_valid), .rtk_ready(b_rtk_ready),
        .round(b_round), .last(b_last), .rewind(b_rewind)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model for instance B ----------------
    localparam int BROUNDS = 56;
    int          pt [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 4, 3, 1, 5, 2, 7, 0, 6};
    logic [7:0]  m_tk  [3][16];
    logic [7:0]  m_tk0 [3][16];
    int          m_round;
    bit          m_run;

    function automatic logic [7:0] tk2_lfsr(input logic [7:0] x);
        logic [7:0] fb;
        fb = ((x >> 7) ^ (x >> 5)) & 8'h01;
        return (x << 1) | fb;
    endfunction

    function automatic logic [7:0] tk3_lfsr(input logic [7:0] x);
        logic [7:0] fb;
        fb = (x ^ (x >> 6)) & 8'h01;
        return (x >> 1) | (fb << 7);
    endfunction

    task automatic model_step();
        logic [7:0] tmp [16];
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) tmp[i] = m_tk[w][pt[i]];
            for (int i = 8; i < 16; i++) begin
                if (w == 1) tmp[i] = tk2_lfsr(tmp[i]);
                if (w == 2) tmp[i] = tk3_lfsr(tmp[i]);
            end
            for (int i = 0; i < 16; i++) m_tk[w][i] = tmp[i];
        end
    endtask

    function automatic logic [63:0] model_rtk();
        logic [63:0] r;
        r = '0;
        for (int i = 8; i < 16; i++)
            for (int w = 0; w < 3; w++)
                r[(i-8)*8 +: 8] = r[(i-8)*8 +: 8] ^ m_tk[w][i];
        return r;
    endfunction

    // Apply one clock with the given ready level and advance the model
    task automatic b_cycle(input bit rdy);
        b_rtk_ready = rdy;
        tick();
        if (rdy && m_run) begin
            if (m_round == BROUNDS - 1) begin
                m_run = 1'b0;
            end else begin
                model_step();
                m_round++;
            end
        end
    endtask

    task automatic b_check_all(input string tag);
        check({tag, "_valid"}, 64'(b_rtk_valid), 64'(m_run));
        check({tag, "_lready"}, 64'(b_load_ready), 64'(!m_run));
        check({tag, "_last"}, 64'(b_last), 64'(m_run && m_round == BROUNDS - 1));
        if (m_run) begin
            check({tag, "_round"}, 64'(b_round), 64'(m_round));
            check({tag, "_rtk"}, b_rtk, model_rtk());
        end
    endtask

    task automatic b_load_random();
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 16; i++) begin
                m_tk[w][i] = 8'($urandom);
                b_tk_in[(w*16+i)*8 +: 8] = m_tk[w][i];
            end
        m_tk0 = m_tk;
        b_load_valid = 1'b1;
        tick();
        b_load_valid = 1'b0;
        m_round = 0;
        m_run   = 1'b1;
    endtask

    logic [63:0] saved_rtk;
    logic [63:0] post_load_rtk;
    logic [5:0]  saved_round;

    initial begin
        rst = 1'b1;
        a_tk_in = '0; a_load_valid = 1'b0; a_rtk_ready = 1'b0; a_rewind = 1'b0;
        b_tk_in = '0; b_load_valid = 1'b0; b_rtk_ready = 1'b0; b_rewind = 1'b0;
        m_run = 1'b0; m_round = 0;
        tick();
        tick();

        // Reset state
        check("a_rst_lready", 64'(a_load_ready), 64'd1);
        check("a_rst_valid", 64'(a_rtk_valid), 64'd0);
        check("a_rst_rtk", a_rtk, 64'd0);
        check("a_rst_round", 64'(a_round), 64'd0);
        check("a_rst_last", 64'(a_last), 64'd0);
        check("b_rst_rtk", b_rtk, 64'd0);
        rst = 1'b0;
        tick();

        // Known answer: TK1 cell k = k
        for (int k = 0; k < 16; k++) a_tk_in[k*8 +: 8] = 8'(k);
        a_load_valid = 1'b1;
        tick();
        a_load_valid = 1'b0;
        check("a_load_valid", 64'(a_rtk_valid), 64'd1);
        check("a_load_lready", 64'(a_load_ready), 64'd0);
        check("a_load_rtk", a_rtk, 64'h0F0E0D0C0B0A0908);
        check("a_load_round", 64'(a_round), 64'd0);
        check("a_load_last", 64'(a_last), 64'd0);

        a_rtk_ready = 1'b1;
        tick();
        check("a_r1_rtk", a_rtk, 64'h0600070205010304);
        check("a_r1_round", 64'(a_round), 64'd1);
        check("a_r1_last", 64'(a_last), 64'd0);
        tick();
        check("a_r2_round", 64'(a_round), 64'd2);
        check("a_r2_last", 64'(a_last), 64'd1);
        tick();
        check("a_end_lready", 64'(a_load_ready), 64'd1);
        check("a_end_valid", 64'(a_rtk_valid), 64'd0);
        check("a_end_last", 64'(a_last), 64'd0);
        a_rtk_ready = 1'b0;

        // Full random-handshake run on instance B
        b_load_random();
        b_check_all("b_load");
        for (int c = 0; c < 400 && m_run; c++) begin
            b_cycle(1'($urandom_range(0, 1)));
            b_check_all("b_rand");
        end
        check("b_rand_done", 64'(b_load_ready), 64'd1);

        // Stall for 5 cycles with a competing load attempt
        b_load_random();
        post_load_rtk = model_rtk();
        check("b_post_load_rtk", b_rtk, post_load_rtk);
        for (int c = 0; c < 3; c++) b_cycle(1'b1);
        b_check_all("b_pre_stall");
        saved_rtk   = b_rtk;
        saved_round = b_round;
        b_load_valid = 1'b1;
        b_tk_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            b_cycle(1'b0);
            check("b_stall_rtk", b_rtk, saved_rtk);
            check("b_stall_round", 64'(b_round), 64'(saved_round));
            b_check_all("b_stall");
        end
        b_load_valid = 1'b0;

        // Rewind together with a handshake at round 4
        b_cycle(1'b1);
        check("b_pre_rewind_round", 64'(b_round), 64'd4);
        b_rewind    = 1'b1;
        b_rtk_ready = 1'b1;
        tick();
        b_rewind    = 1'b0;
        b_rtk_ready = 1'b0;
`ifdef TWEAKEY_REWIND_EN
        m_tk    = m_tk0;
        m_round = 0;
        check("b_rewind_round", 64'(b_round), 64'd0);
        check("b_rewind_rtk", b_rtk, post_load_rtk);
`else
        model_step();
        m_round++;
        check("b_norewind_round", 64'(b_round), 64'd5);
`endif
        b_check_all("b_after_rewind");

        // Reset in the middle of a run at round 10
        for (int c = 0; c < 40 && m_round < 10; c++) b_cycle(1'b1);
        check("b_pre_rst_round", 64'(b_round), 64'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_run = 1'b0;
        check("b_rst_valid", 64'(b_rtk_valid), 64'd0);
        check("b_rst_lready", 64'(b_load_ready), 64'd1);
        check("b_rst_rtk2", b_rtk, 64'd0);
        check("b_rst_round", 64'(b_round), 64'd0);
        check("b_rst_last", 64'(b_last), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
